// File: rtl/vram_arbiter_if.sv
// Bus bundle between the video RAM arbiter, its CPU requester, the timing
// generator, the tile pipeline and the RAM macro.
interface vram_arbiter_if;
  logic [8:0]  hpos;
  logic [8:0]  vpos;
  logic        hblk;
  logic        vblk;
  // CPU handshake: the CPU holds cpu_req with cpu_we/cpu_addr/cpu_do stable.
  // cpu_wait is high while the request is pending. cpu_ack pulses for one
  // cycle with cpu_di valid. The CPU must then drop cpu_req before it starts
  // a new request.
  logic        cpu_req;
  logic        cpu_we;
  logic [11:0] cpu_addr;
  logic [7:0]  cpu_do;
  logic [7:0]  cpu_di;
  logic        cpu_ack;
  logic        cpu_wait;
  logic [11:0] ram_addr;
  logic        ram_we;
  logic [7:0]  ram_do;
  logic [7:0]  ram_di;
  logic [7:0]  tile_code;
  logic [7:0]  tile_attr;
  logic        tile_stb;

  modport slave (
    input  hpos, vpos, hblk, vblk, cpu_req, cpu_we, cpu_addr, cpu_do, ram_di,
    output cpu_di, cpu_ack, cpu_wait, ram_addr, ram_we, ram_do,
           tile_code, tile_attr, tile_stb
  );

  modport master (
    output hpos, vpos, hblk, vblk, cpu_req, cpu_we, cpu_addr, cpu_do, ram_di,
    input  cpu_di, cpu_ack, cpu_wait, ram_addr, ram_we, ram_do,
           tile_code, tile_attr, tile_stb
  );
endinterface

// File: rtl/vram_arbiter.sv
// Time-slot arbiter for the video RAM port. Slots 0-3 of every 8-pixel tile in
// the video window belong to the tile fetch, and all other cycles go to the CPU.
module vram_arbiter (
  input  logic             clk,
  input  logic             rst_n,
  vram_arbiter_if.slave    bus,
  output logic [1:0]       dbg_state
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DATA = 2'd1,
    HOLD = 2'd2
  } cpu_state_t;

  cpu_state_t  state;
  cpu_state_t  state_next;
  logic [2:0]  slot;
  logic [5:0]  col;
  logic        vw;
  logic        video_own;
  logic        grant;
  logic [7:0]  code_pre;
  logic [7:0]  attr_pre;
  logic        vpos_unused;

  assign slot        = bus.hpos[2:0];
  // Fetch targets the next column, so the last column wraps to column 0.
  assign col         = bus.hpos[8:3] + 6'd1;
  assign vw          = ~bus.vblk & (~bus.hblk | (bus.hpos[8:3] == 6'd63));
  assign video_own   = vw & ~slot[2];
  assign dbg_state   = state;
  assign vpos_unused = ^{bus.vpos[8], bus.vpos[2:0]};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next   = state;
    grant        = 1'b0;
    bus.ram_addr = 12'h000;
    bus.ram_we   = 1'b0;
    bus.ram_do   = 8'h00;
    bus.cpu_wait = bus.cpu_req & (state != HOLD);
    case (state)
      IDLE: begin
        // rst_n gates the grant so a held request cannot reach the RAM in reset.
        if (bus.cpu_req && !video_own && rst_n) begin
          grant      = 1'b1;
          state_next = DATA;
        end
      end
      DATA:    state_next = HOLD;
      HOLD:    if (!bus.cpu_req) state_next = IDLE;
      default: state_next = IDLE;
    endcase
    if (grant) begin
      bus.ram_addr = bus.cpu_addr;
      bus.ram_we   = bus.cpu_we;
      bus.ram_do   = bus.cpu_do;
    end else if (vw && slot == 3'd0) begin
      bus.ram_addr = {1'b0, bus.vpos[7:3], col};
    end else if (vw && slot == 3'd2) begin
      bus.ram_addr = {1'b1, bus.vpos[7:3], col};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.cpu_ack   <= 1'b0;
      bus.cpu_di    <= 8'h00;
      code_pre      <= 8'h00;
      attr_pre      <= 8'h00;
      bus.tile_code <= 8'h00;
      bus.tile_attr <= 8'h00;
      bus.tile_stb  <= 1'b0;
    end else begin
      // Write data is also captured here, so writes return whatever the RAM
      // presents in the DATA cycle.
      bus.cpu_ack <= (state == DATA);
      if (state == DATA) bus.cpu_di <= bus.ram_di;
      if (vw && slot == 3'd1) code_pre <= bus.ram_di;
      if (vw && slot == 3'd3) attr_pre <= bus.ram_di;
      bus.tile_stb <= vw && (slot == 3'd7);
      if (vw && slot == 3'd7) begin
        bus.tile_code <= code_pre;
        bus.tile_attr <= attr_pre;
      end
    end
  end

endmodule
